if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
IF/ID pipeline stage directly downstream of the fetch stage. Registers the fetched instruction and its PC and extracts the register fields. Detects load-use hazards and drives the fetch-stage stall. Squashes wrong-path instructions when a branch is taken; the taken branch resolves two stages after fetch.

Parameters:
XLEN, 32, datapath and PC width
NOP_INST, 32'h0000_0013, instruction injected on bubble or flush (addi x0,x0,0)
FLUSH_DEPTH, 2, wrong-path instructions squashed per taken branch

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
inst_in  in  32  instruction word from fetch ROM
pc_in  in  XLEN  PC associated with inst_in
doBranch  in  1  taken-branch pulse from EX, same signal that fetch consumes
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
stall  out  1  hold request to fetch; combinational
id_bubble  out  1  tells ID/EX to latch a NOP this cycle; combinational
inst_out  out  32  registered instruction
pc_out  out  XLEN  registered PC
valid_out  out  1  inst_out is a real (non-squashed) instruction
rs1, rs2, rd  out  5  inst_out[19:15], [24:20], [11:7]
opcode  out  7  inst_out[6:0]
stall_cycles  out  32  performance counter (see optional feature)
flush_cycles  out  32  performance counter (see optional feature)

Behaviour:
- Reset (rst=0, async): inst_out=NOP_INST, pc_out=0, valid_out=0, state=RUN, flush counter=0, perf counters=0. rs1/rs2/rd/opcode follow NOP_INST. stall=0, id_bubble=0 while reset is held.
- Field decode is purely combinational from inst_out; zero added latency.
- Hazard (combinational): haz = valid_out & ex_mem_read & (ex_rd!=0) & uses & (ex_rd==rs1 | (ex_rd==rs2 & uses_rs2)).
  - uses = opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
  - uses_rs2 = opcode in {R 0110011, S 0100011, B 1100011}.
- stall = haz & (state==RUN) & ~doBranch. id_bubble = stall.
- FSM with states RUN and FLUSH:
  - RUN, doBranch=1: latch NOP_INST, valid_out=0, pc_out=pc_in. Load flush counter with FLUSH_DEPTH-1. If FLUSH_DEPTH-1 > 0, go to FLUSH; otherwise stay in RUN.
  - RUN, stall=1: hold inst_out, pc_out and valid_out unchanged.
  - RUN, otherwise: latch inst_in and pc_in; valid_out=1.
  - FLUSH: latch NOP_INST, valid_out=0, pc_out=pc_in, decrement counter. Leave for RUN when the counter reaches 0 (the final squash cycle is the transition).
  - FLUSH, doBranch=1: must not occur, because a squashed instruction cannot branch. If it does, reload the counter; there is no assertion.
- Priority: reset > doBranch > stall > normal capture.
  - doBranch and hazard in the same cycle: branch wins; stall=0 and the stalled instruction is squashed.
- Hazard persists at most 1 cycle: after the hold, the load advances to MEM, so ex_rd no longer matches.
- pc_out wraps modulo 2^XLEN; it is stored as-is, with no arithmetic.

Optional Feature:
Macro IF_ID_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with stall=1. flush_cycles increments on every cycle that latches a squash NOP (the doBranch cycle plus the FLUSH cycles). Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: no counter flops are built; both outputs are tied to 32'b0. The ports are present in either case.

Test Plan:
- Reset and release: hold rst=0 for 3 cycles with random inst_in -> inst_out=32'h00000013, valid_out=0, pc_out=0, stall=0. First posedge after release with inst_in=32'h00500093, pc_in=0 -> inst_out=32'h00500093, rd=1, valid_out=1.
- Load-use: inst_out=add x3,x1,x2 (32'h002081B3), ex_mem_read=1, ex_rd=1 -> stall=1 and id_bubble=1 for exactly one cycle, inst_out held. Same setup with ex_rd=0 -> stall=0.
- No false hazard: inst_out=lui x1,0x12 (32'h000120B7), ex_mem_read=1, ex_rd=0 -> stall=0. Addi with rs2 field=5, ex_rd=5 -> stall=0.
- Branch flush: doBranch pulsed for 1 cycle with valid instructions streaming -> valid_out=0 and inst_out=NOP for exactly 2 consecutive cycles, then valid resumes. With the macro defined, flush_cycles=2.
- Simultaneous branch and hazard: haz conditions true while doBranch=1 -> stall=0, squash proceeds. With the macro defined, stall_cycles is unchanged.
- Async reset mid-flush: assert rst=0 between clock edges during FLUSH -> outputs return to reset values immediately; after release, the first capture is a normal RUN capture.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch <-> IF/ID handshake bundle: fetched instruction/PC, taken-branch pulse
// and the stall request back to fetch.
interface if_id_stage_if #(
    parameter int XLEN = 32
);
    logic [31:0]     inst_in;
    logic [XLEN-1:0] pc_in;
    logic            doBranch;
    logic            stall;

    modport master (
        output inst_in,
        output pc_in,
        output doBranch,
        input  stall
    );

    modport slave (
        input  inst_in,
        input  pc_in,
        input  doBranch,
        output stall
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall and taken-branch squash.
// Optional performance counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_stage #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter int          FLUSH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_id_stage_if.slave    fetch,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic            id_bubble,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_cycles
);
    localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     flush_cnt_reg, flush_cnt_next;
    logic [31:0]       inst_reg, inst_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic              valid_reg, valid_next;
    logic              uses, uses_rs2, haz, stall, squash;

    assign inst_out  = inst_reg;
    assign pc_out    = pc_reg;
    assign valid_out = valid_reg;
    assign opcode    = inst_reg[6:0];
    assign rd        = inst_reg[11:7];
    assign rs1       = inst_reg[19:15];
    assign rs2       = inst_reg[24:20];

    // U-type and JAL carry no source registers; only R/S/B read rs2.
    assign uses     = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign haz      = valid_reg & ex_mem_read & (ex_rd != 5'd0) & uses &
                      ((ex_rd == rs1) | ((ex_rd == rs2) & uses_rs2));

    assign stall       = haz & (state_reg == RUN) & ~fetch.doBranch;
    assign fetch.stall = stall;
    assign id_bubble   = stall;
    assign squash      = ((state_reg == RUN) & fetch.doBranch) | (state_reg == FLUSH);

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        inst_next      = inst_reg;
        pc_next        = pc_reg;
        valid_next     = valid_reg;
        if (squash) begin
            inst_next  = NOP_INST;
            pc_next    = fetch.pc_in;
            valid_next = 1'b0;
        end
        case (state_reg)
            RUN: begin
                if (fetch.doBranch) begin
                    flush_cnt_next = CW'(FLUSH_DEPTH - 1);
                    if (FLUSH_DEPTH > 1)
                        state_next = FLUSH;
                end else if (!stall) begin
                    inst_next  = fetch.inst_in;
                    pc_next    = fetch.pc_in;
                    valid_next = 1'b1;
                end
            end
            FLUSH: begin
                // A branch here is not expected; reloading keeps the squash window safe.
                if (fetch.doBranch && FLUSH_DEPTH > 1) begin
                    flush_cnt_next = CW'(FLUSH_DEPTH - 1);
                end else if (flush_cnt_reg <= CW'(1)) begin
                    flush_cnt_next = '0;
                    state_next     = RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg - CW'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            flush_cnt_reg <= '0;
            inst_reg      <= NOP_INST;
            pc_reg        <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            inst_reg      <= inst_next;
            pc_reg        <= pc_next;
            valid_reg     <= valid_next;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, flush_cyc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cyc_reg <= '0;
        end else begin
            if (stall)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (squash)
                flush_cyc_reg <= flush_cyc_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cyc_reg;
`else
    assign stall_cycles = 32'b0;
    assign flush_cycles = 32'b0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, load-use stall, hazard filtering,
// branch squash, branch/hazard collision and asynchronous reset mid-flush.
module tb_if_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        id_bubble;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [31:0] stall_cycles, flush_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    if_id_stage_if #(.XLEN(32)) fetch_bus ();

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .fetch        (fetch_bus.slave),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .id_bubble    (id_bubble),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .valid_out    (valid_out),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .opcode       (opcode),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
            $display("[%0t] %s observed=%h expected=%h ok", $time, tag, obs, exp_v);
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic feed(input logic [31:0] inst, input logic [31:0] pc);
        fetch_bus.inst_in = inst;
        fetch_bus.pc_in   = pc;
    endtask

    initial begin
        rst                = 1'b0;
        ex_mem_read        = 1'b0;
        ex_rd              = 5'd0;
        fetch_bus.doBranch = 1'b0;
        feed(32'h0, 32'h0);

        // Reset held for 3 cycles with random fetch data
        for (int i = 0; i < 3; i++) begin
            feed($urandom, $urandom);
            tick();
        end
        chk("rst_inst",  inst_out, NOP);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_pc",    pc_out, 32'd0);
        chk("rst_stall", {31'b0, fetch_bus.stall}, 32'd0);
        chk("rst_bubble", {31'b0, id_bubble}, 32'd0);
        chk("rst_rd",    {27'b0, rd}, 32'd0);
        chk("rst_opcode", {25'b0, opcode}, 32'h13);

        // Release and first capture: addi x1,x0,5
        rst = 1'b1;
        feed(32'h0050_0093, 32'h0);
        tick();
        chk("cap_inst",  inst_out, 32'h0050_0093);
        chk("cap_rd",    {27'b0, rd}, 32'd1);
        chk("cap_valid", {31'b0, valid_out}, 32'd1);

        // addi rs2 field = 5 and ex_rd = 5: no rs2 use, no hazard
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        #1;
        chk("addi_rs2_nohaz", {31'b0, fetch_bus.stall}, 32'd0);
        ex_mem_read = 1'b0;

        // Load-use on add x3,x1,x2
        feed(32'h0020_81B3, 32'h4);
        tick();
        chk("add_rs1", {27'b0, rs1}, 32'd1);
        chk("add_rs2", {27'b0, rs2}, 32'd2);
        chk("add_rd",  {27'b0, rd}, 32'd3);
        ex_mem_read = 1'b1;
        ex_rd       = 5'd1;
        feed(32'h00A0_0113, 32'h8);
        #1;
        chk("lu_stall",  {31'b0, fetch_bus.stall}, 32'd1);
        chk("lu_bubble", {31'b0, id_bubble}, 32'd1);
        tick();
        chk("lu_hold_inst", inst_out, 32'h0020_81B3);
        chk("lu_hold_pc",   pc_out, 32'h4);
        ex_mem_read = 1'b0;
        #1;
        chk("lu_release", {31'b0, fetch_bus.stall}, 32'd0);
        tick();
        chk("lu_adv_inst", inst_out, 32'h00A0_0113);
        chk("lu_adv_pc",   pc_out, 32'h8);
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_stall1", stall_cycles, 32'd1);
`endif

        // Same add with ex_rd = 0, then rs2 match
        feed(32'h0020_81B3, 32'hC);
        tick();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        #1;
        chk("x0_nohaz", {31'b0, fetch_bus.stall}, 32'd0);
        ex_rd = 5'd2;
        #1;
        chk("rs2_haz", {31'b0, fetch_bus.stall}, 32'd1);
        ex_mem_read = 1'b0;

        // lui x1,0x12: rs1 field is 2 but lui reads no registers
        feed(32'h0001_20B7, 32'h10);
        tick();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        #1;
        chk("lui_x0", {31'b0, fetch_bus.stall}, 32'd0);
        ex_rd = 5'd2;
        #1;
        chk("lui_field2", {31'b0, fetch_bus.stall}, 32'd0);
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;

        // Branch flush with valid instructions streaming
        feed(32'h0010_0193, 32'h20);
        tick();
        chk("br_pre_valid", {31'b0, valid_out}, 32'd1);
        feed(32'h0020_0213, 32'h24);
        fetch_bus.doBranch = 1'b1;
        tick();
        fetch_bus.doBranch = 1'b0;
        chk("br_sq1_inst",  inst_out, NOP);
        chk("br_sq1_valid", {31'b0, valid_out}, 32'd0);
        chk("br_sq1_pc",    pc_out, 32'h24);
        feed(32'h0030_0293, 32'h28);
        tick();
        chk("br_sq2_inst",  inst_out, NOP);
        chk("br_sq2_valid", {31'b0, valid_out}, 32'd0);
        chk("br_sq2_pc",    pc_out, 32'h28);
        feed(32'h0020_81B3, 32'h2C);
        tick();
        chk("br_resume_inst",  inst_out, 32'h0020_81B3);
        chk("br_resume_valid", {31'b0, valid_out}, 32'd1);
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_flush2", flush_cycles, 32'd2);
`endif

        // Branch and hazard together: branch wins
        ex_mem_read        = 1'b1;
        ex_rd              = 5'd1;
        fetch_bus.doBranch = 1'b1;
        feed(32'h0040_0313, 32'h30);
        #1;
        chk("col_stall",  {31'b0, fetch_bus.stall}, 32'd0);
        chk("col_bubble", {31'b0, id_bubble}, 32'd0);
        tick();
        fetch_bus.doBranch = 1'b0;
        ex_mem_read        = 1'b0;
        chk("col_sq_inst",  inst_out, NOP);
        chk("col_sq_valid", {31'b0, valid_out}, 32'd0);
        feed(32'h0050_0393, 32'h34);
        tick();
        chk("col_sq2_valid", {31'b0, valid_out}, 32'd0);
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_stall_same", stall_cycles, 32'd1);
        chk("perf_flush4",     flush_cycles, 32'd4);
`endif

        // Async reset while in FLUSH
        feed(32'h0060_0413, 32'h40);
        tick();
        chk("ar_pre_valid", {31'b0, valid_out}, 32'd1);
        feed(32'h0070_0493, 32'h44);
        fetch_bus.doBranch = 1'b1;
        tick();
        fetch_bus.doBranch = 1'b0;
        chk("ar_flush_pc", pc_out, 32'h44);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_pc",    pc_out, 32'd0);
        chk("ar_inst",  inst_out, NOP);
        chk("ar_valid", {31'b0, valid_out}, 32'd0);
`ifdef IF_ID_PERF_CNT_EN
        chk("ar_perf_flush", flush_cycles, 32'd0);
`endif
        tick();
        rst = 1'b1;
        feed(32'h0080_0513, 32'h50);
        tick();
        chk("ar_cap_inst",  inst_out, 32'h0080_0513);
        chk("ar_cap_valid", {31'b0, valid_out}, 32'd1);
        chk("ar_cap_pc",    pc_out, 32'h50);

        // PC stored as-is at the top of the address space
        feed(32'h0090_0593, 32'hFFFF_FFFC);
        tick();
        chk("pc_top", pc_out, 32'hFFFF_FFFC);
        chk("run_valid", {31'b0, valid_out}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
